// File: rtl/cnn_pkg.sv
// Shared types and constants for the MNIST CNN layer scheduler.
package cnn_pkg;

  localparam int NUM_LAYERS = 4;

  typedef enum logic [1:0] {
    L_CONV2 = 2'd0,
    L_CONV4 = 2'd1,
    L_FC6   = 2'd2,
    L_FC7   = 2'd3
  } layer_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SEND  = 3'd2,
    S_DRAIN = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/cnn_credit_cnt.sv
// Inflight beat counter between the sender and the receiver.
// Saturates at all-ones and holds at zero, and flags both cases.
module cnn_credit_cnt #(
  parameter int CNT_W        = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             stall_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign ovf_o = inc_i && !dec_i && (cnt_q == CNT_MAX);
  assign unf_o = dec_i && !inc_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !ovf_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !unf_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign stall_o = (cnt_q >= STALL_AT);

endmodule

// File: rtl/cnn_layer_sched.sv
// Sequences one image through CONV2, CONV4, FC6, FC7 and gates each layer on a full drain.
// Define CNN_SCHED_WDOG_EN to add a drain watchdog that aborts the image after WDOG_CYCLES quiet cycles.
//
// state   | meaning
// IDLE    | waiting for img_start
// START   | layer_start pulse for layer_id
// SEND    | sender streaming, waiting for snd_done
// DRAIN   | waiting for inflight==0 and rcv_done
// NEXT    | advance layer or finish image
// DONE    | img_done pulse, back to IDLE
module cnn_layer_sched
  import cnn_pkg::*;
#(
  parameter int NUM_LAYERS   = cnn_pkg::NUM_LAYERS,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       img_start,
  output logic [1:0] layer_id,
  output logic       layer_start,
  input  logic       snd_done,
  input  logic       valid_i,
  input  logic       valid_o,
  input  logic       rcv_done,
  output logic       stall,
  output logic       busy,
  output logic       img_done,
  output logic       err
);

  if (WDOG_CYCLES < 2 || (1 << CNT_W) <= MAX_INFLIGHT) begin : g_bad_param
    $error("cnn_layer_sched: invalid CNT_W/MAX_INFLIGHT/WDOG_CYCLES");
  end

  sched_state_e state_q, state_d;
  layer_e       layer_q, layer_d;
  logic         rcv_seen_q, rcv_seen_d;
  logic         layer_start_q, layer_start_d;
  logic         busy_q, busy_d;
  logic         img_done_q, img_done_d;
  logic         err_q, err_d;

  logic [CNT_W-1:0] inflight;
  logic             ovf, unf, wdog_to;
  logic             active, drain_ok, last_layer, accept;

  assign active     = (state_q != S_IDLE);
  assign accept     = (state_q == S_IDLE) && img_start;
  assign last_layer = (layer_q == 2'(NUM_LAYERS - 1));
  assign drain_ok   = (state_q == S_DRAIN) && (inflight == '0) && (rcv_seen_q || rcv_done);

  cnn_credit_cnt #(
    .CNT_W       (CNT_W),
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_credit (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (valid_i && active),
    .dec_i  (valid_o && active),
    .clr_i  (wdog_to),
    .cnt_o  (inflight),
    .stall_o(stall),
    .ovf_o  (ovf),
    .unf_o  (unf)
  );

`ifdef CNN_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);
  logic [WD_W-1:0] wdog_q, wdog_d;

  // Any return beat or rcv_done counts as progress and restarts the window.
  always_comb begin
    wdog_d  = '0;
    wdog_to = 1'b0;
    if (state_q == S_DRAIN && !valid_o && !rcv_done) begin
      if (wdog_q == WD_W'(WDOG_CYCLES - 1)) wdog_to = 1'b1;
      else                                  wdog_d  = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign wdog_to = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      layer_q       <= L_CONV2;
      rcv_seen_q    <= 1'b0;
      layer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      img_done_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      rcv_seen_q    <= rcv_seen_d;
      layer_start_q <= layer_start_d;
      busy_q        <= busy_d;
      img_done_q    <= img_done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (img_start) state_d = S_START;
      S_START: state_d = S_SEND;
      S_SEND:  if (snd_done) state_d = S_DRAIN;
      S_DRAIN: begin
        if (wdog_to)       state_d = S_IDLE;
        else if (drain_ok) state_d = S_NEXT;
      end
      S_NEXT:  state_d = last_layer ? S_DONE : S_START;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    layer_d = layer_q;
    if (state_q == S_NEXT && !last_layer)            layer_d = layer_e'(layer_q + 2'd1);
    else if (state_q == S_DONE || state_q == S_IDLE) layer_d = L_CONV2;

    rcv_seen_d = ((state_d == S_SEND) || (state_d == S_DRAIN)) &&
                 (rcv_seen_q || (rcv_done && ((state_q == S_SEND) || (state_q == S_DRAIN))));

    layer_start_d = (state_d == S_START);
    busy_d        = (state_d != S_IDLE);
    img_done_d    = (state_d == S_DONE);
    err_d         = (accept ? 1'b0 : err_q) | ovf | unf | wdog_to |
                    ((state_q == S_IDLE) && valid_o);
  end

  assign layer_id    = layer_q;
  assign layer_start = layer_start_q;
  assign busy        = busy_q;
  assign img_done    = img_done_q;
  assign err         = err_q;

endmodule

// File: doc/cnn_layer_sched.md
# cnn_layer_sched

Layer scheduler for the MNIST CNN. It sequences one image through the four compute layers, in order: CONV2, CONV4, FC6 and FC7. It tells the sender which layer to stream and when to start. It tracks how many MAC-array results are still outstanding, so the sender can be throttled. It releases the next layer only after the receiver has written back every result of the current layer. It sits beside the sender, the MAC array and the receiver inside the top-level controller.

## Interface
Parameters:
- NUM_LAYERS, 4, number of layers sequenced per image
- MAX_INFLIGHT, 8, outstanding valid_i beats allowed before stall asserts
- CNT_W, 4, inflight counter width; must satisfy 2^CNT_W > MAX_INFLIGHT
- WDOG_CYCLES, 1024, drain watchdog limit (only with CNN_SCHED_WDOG_EN)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- img_start  in  1  pulse: first pixel of a new image accepted
- layer_id  out  2  current layer: 0=CONV2, 1=CONV4, 2=FC6, 3=FC7
- layer_start  out  1  one-cycle pulse: sender begins streaming layer_id
- snd_done  in  1  pulse: sender has issued its last valid_i for the layer
- valid_i  in  1  beat issued into mac_array
- valid_o  in  1  beat returned from mac_array
- rcv_done  in  1  pulse: receiver has committed the layer's last write
- stall  out  1  sender must not issue valid_i this cycle
- busy  out  1  an image is in progress
- img_done  out  1  one-cycle pulse: FC7 complete
- err  out  1  sticky error; cleared only by rst or by the next accepted img_start

## Operation
- States: IDLE, START, SEND, DRAIN, NEXT, DONE.
- IDLE:
  - img_start goes to START.
  - Any other input in IDLE is ignored.
  - A stray valid_o in IDLE is the exception: it sets err.
- START: drive layer_start=1 for this cycle only, then go to SEND.
- SEND: wait for snd_done, then go to DRAIN.
- DRAIN: leave only when both of these have held:
  - inflight==0;
  - rcv_done seen. rcv_done may arrive before or after inflight reaches 0, and the block latches it.
- NEXT:
  - If layer_id==NUM_LAYERS-1, go to DONE.
  - Otherwise increment layer_id and go to START.
- DONE: drive img_done=1 for one cycle, reset layer_id to 0, go to IDLE.
- busy=1 in every state except IDLE.
- img_start while busy is ignored; the current image is not disturbed.
- Inflight counter updates:
  - valid_i alone: +1.
  - valid_o alone: -1.
  - Both in the same cycle: unchanged.
- stall = (inflight >= MAX_INFLIGHT). It is combinational from the registered counter.
- Counter limits:
  - valid_i while the counter is at 2^CNT_W-1: counter saturates and err sets.
  - valid_o while the counter is at 0: counter holds at 0 and err sets.
- snd_done outside SEND and rcv_done outside SEND/DRAIN are ignored. rcv_done is latched during SEND as well.

## Timing
- Reset values:
  - state=IDLE, layer_id=0, inflight=0;
  - layer_start=0, stall=0, busy=0, img_done=0, err=0.
- Asserting rst mid-image aborts immediately. No img_done is produced.
- Per-layer latency:
  - img_start at cycle t gives layer_start at t+1.
  - A layer whose drain condition is met at cycle d gives NEXT at d+1 and the next layer_start at d+2.
- Per-image latency: the final drain gives img_done at d+2 and busy=0 at d+3.
- layer_id is stable from layer_start through the end of DRAIN.
- All outputs are registered except stall.

## Configuration
- CNN_SCHED_WDOG_EN defined:
  - A watchdog counts the cycles spent in DRAIN without a valid_o or rcv_done.
  - At WDOG_CYCLES it sets err, clears inflight, and returns to IDLE. No img_done is produced.
- CNN_SCHED_WDOG_EN undefined: no watchdog logic; DRAIN waits indefinitely.

## Structure
- cnn_pkg holds:
  - the layer_e enum (L_CONV2, L_CONV4, L_FC6, L_FC7);
  - the sched_state_e enum;
  - NUM_LAYERS.
- Sub-module cnn_credit_cnt owns the inflight up/down counter, the saturation/underflow flags and the stall compare. It is parameterised by CNT_W and MAX_INFLIGHT.

## Test plan
- Nominal image:
  - Stimulus: img_start, then each layer sends 3 valid_i, returns 3 valid_o, then snd_done and rcv_done.
  - Response: layer_start pulses 4 times with layer_id 0,1,2,3; exactly one img_done; err=0.
- Stall:
  - Stimulus: 8 valid_i with no valid_o.
  - Response: stall=1 after the 8th beat. One valid_o drops stall on the next cycle.
- Simultaneous beats:
  - Stimulus: valid_i and valid_o together for 5 cycles at inflight=3.
  - Response: inflight stays 3.
- Early rcv_done:
  - Stimulus: rcv_done in SEND, with 2 beats still inflight.
  - Response: NEXT only after the 2nd valid_o. img_start during busy is ignored.
- Error and reset:
  - Stimulus: valid_o at inflight=0.
  - Response: err=1 and stays set. rst mid-CONV4 returns all outputs to their reset values with no img_done.
- Watchdog (macro on, WDOG_CYCLES=16):
  - Stimulus: stop valid_o in DRAIN.
  - Response: err=1 at 16 cycles, state returns to IDLE, no img_done.
